// File: rtl/ar_outstanding_limiter_if.sv
// AXI read-address channel bundle: valid/ready handshake plus AR payload fields.
// master drives valid and payload, slave drives ready.
interface ar_outstanding_limiter_if #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2,
  parameter int QOS_WIDTH   = 4
);
  logic                   valid;
  logic                   ready;
  logic [ID_WIDTH-1:0]    id;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   len;
  logic [SIZE_WIDTH-1:0]  size;
  logic [BURST_WIDTH-1:0] burst;
  logic [QOS_WIDTH-1:0]   qos;

  modport master (output valid, id, addr, len, size, burst, qos, input ready);
  modport slave  (input valid, id, addr, len, size, burst, qos, output ready);
endinterface

// File: rtl/ar_outstanding_limiter.sv
// AR credit gate: admits reads while global and per-ID in-flight counts are below limit,
// returns credit on R last-beat handshakes; single registered AR stage, full throughput.
module ar_outstanding_limiter #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int BURST_WIDTH     = 2,
  parameter int QOS_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int MAX_PER_ID      = 4,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  ar_outstanding_limiter_if.slave     ar_in,
  ar_outstanding_limiter_if.master    ar_out,
  input  logic                        r_mon_valid,
  input  logic                        r_mon_ready,
  input  logic                        r_mon_last,
  input  logic [ID_WIDTH-1:0]         r_mon_id,
  output logic [CNT_W-1:0]            outstanding,
  output logic                        limit_stall,
  output logic                        err_underflow
);
  localparam int NUM_IDS = 1 << ID_WIDTH;
  localparam int PER_W   = $clog2(MAX_PER_ID + 1);

  logic                   ar_out_valid_q, ar_out_valid_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [SIZE_WIDTH-1:0]  size_q, size_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [QOS_WIDTH-1:0]   qos_q, qos_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic                   err_q, err_d;
  logic [PER_W-1:0]       id_cnt_q [NUM_IDS];
  logic [PER_W-1:0]       id_cnt_d [NUM_IDS];
  logic [NUM_IDS-1:0]     id_inc, id_dec;

  logic slot_free, credit_ok, accept, ret;

  // credit_ok deliberately uses registered counts: a same-cycle return never unblocks an accept.
  assign slot_free   = !ar_out_valid_q || ar_out.ready;
  assign credit_ok   = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) &&
                       (id_cnt_q[ar_in.id] < PER_W'(MAX_PER_ID));
  assign ar_in.ready = !rst && slot_free && credit_ok;
  assign limit_stall = !rst && ar_in.valid && slot_free && !credit_ok;
  assign accept      = ar_in.valid && ar_in.ready;
  assign ret         = r_mon_valid && r_mon_ready && r_mon_last;

  assign ar_out.valid = ar_out_valid_q;
  assign ar_out.id    = id_q;
  assign ar_out.addr  = addr_q;
  assign ar_out.len   = len_q;
  assign ar_out.size  = size_q;
  assign ar_out.burst = burst_q;
  assign ar_out.qos   = qos_q;
  assign outstanding  = outstanding_q;
  assign err_underflow = err_q;

  always_comb begin
    ar_out_valid_d = ar_out_valid_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    qos_d   = qos_q;
    if (accept) begin
      ar_out_valid_d = 1'b1;
      id_d    = ar_in.id;
      addr_d  = ar_in.addr;
      len_d   = ar_in.len;
      size_d  = ar_in.size;
      burst_d = ar_in.burst;
      qos_d   = ar_in.qos;
    end else if (ar_out.ready) begin
      ar_out_valid_d = 1'b0;
    end
  end

  // Global counter saturates at 0 on a spurious return.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !ret)
      outstanding_d = outstanding_q + CNT_W'(1);
    else if (ret && !accept && outstanding_q != '0)
      outstanding_d = outstanding_q - CNT_W'(1);
    err_d = err_q || (ret && (outstanding_q == '0 || id_cnt_q[r_mon_id] == '0));
  end

  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_id_cnt
    assign id_inc[gi] = accept && (ar_in.id == ID_WIDTH'(gi));
    assign id_dec[gi] = ret && (r_mon_id == ID_WIDTH'(gi));
    assign id_cnt_d[gi] =
      (id_inc[gi] && !id_dec[gi]) ? id_cnt_q[gi] + PER_W'(1) :
      (id_dec[gi] && !id_inc[gi] && id_cnt_q[gi] != '0) ? id_cnt_q[gi] - PER_W'(1) :
      id_cnt_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_out_valid_q <= 1'b0;
      id_q           <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      qos_q          <= '0;
      outstanding_q  <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < NUM_IDS; i++) id_cnt_q[i] <= '0;
    end else begin
      ar_out_valid_q <= ar_out_valid_d;
      id_q           <= id_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      size_q         <= size_d;
      burst_q        <= burst_d;
      qos_q          <= qos_d;
      outstanding_q  <= outstanding_d;
      err_q          <= err_d;
      for (int i = 0; i < NUM_IDS; i++) id_cnt_q[i] <= id_cnt_d[i];
    end
  end
endmodule
